csi2_stat_collector: RTL and testbench
======================================

CSI2_STAT_COLLECTOR -- requirements
Module: csi2_stat_collector

Interface
REQ-001 SHALL have parameter ERR_CNT_WIDTH, default 32, width of each error counter.
REQ-002 SHALL have parameter LN_CNT_WIDTH, default 16, width of lines-per-frame statistics.
REQ-003 SHALL have parameter PX_CNT_WIDTH, default 16, width of pixels-per-line statistics.
REQ-004 SHALL have ports, in order:
- clk_i  in  1  single clock; all logic in this domain.
- rst_i  in  1  asynchronous, active-high reset.
- clear_stat_i  in  1  one-cycle clear pulse from clear-statistics control register.
- header_err_i  in  1  uncorrectable header error pulse.
- corr_header_err_i  in  1  corrected header error pulse.
- crc_err_i  in  1  payload CRC error pulse.
- px_valid_i  in  1  pixel beat valid.
- px_sof_i  in  1  qualifies first beat of frame.
- px_eol_i  in  1  qualifies last beat of line.
- frame_end_i  in  1  frame-end short packet pulse.
- header_err_cnt_o  out  ERR_CNT_WIDTH  to header error status register.
- corr_header_err_cnt_o  out  ERR_CNT_WIDTH  to corrected header error status register.
- crc_err_cnt_o  out  ERR_CNT_WIDTH  to CRC error status register.
- max_ln_per_frame_o / min_ln_per_frame_o  out  LN_CNT_WIDTH each.
- max_px_per_ln_o / min_px_per_ln_o  out  PX_CNT_WIDTH each.

Function
REQ-005 SHALL register all outputs; each output SHALL reflect an event on the cycle after the input event.
REQ-006 Each error counter SHALL increment by 1 per cycle its pulse is high, saturating at all-ones.
REQ-007 FSM states: IDLE (wait for frame start), ACTIVE (frame in progress).
REQ-008 IDLE -> ACTIVE on px_valid_i & px_sof_i; the beat SHALL count as pixel 1 of line 1.
REQ-009 In IDLE, pixel beats without sof, px_eol_i and frame_end_i SHALL be ignored.
REQ-010 In ACTIVE, each px_valid_i beat SHALL increment the internal pixel counter, saturating at all-ones.
REQ-011 On px_valid_i & px_eol_i: line length = pixel count including that beat; max/min px stats updated with it; pixel counter cleared; line counter incremented (saturating).
REQ-012 Beat with both px_sof_i and px_eol_i SHALL be treated as a one-pixel line.
REQ-013 ACTIVE -> IDLE on frame_end_i; if line counter (including a line ending same cycle) is nonzero, max/min line stats SHALL be updated with it; partial line SHALL be discarded.
REQ-014 frame_end_i with zero completed lines SHALL not update line stats.
REQ-015 px_valid_i & px_sof_i in ACTIVE without prior frame_end_i SHALL discard the uncommitted frame (no line-stat update), restart counts with that beat, stay ACTIVE.
REQ-016 Max stats update when sample > stored; min stats when sample < stored; equal leaves value unchanged.
REQ-017 clear_stat_i SHALL, next cycle, return all outputs and internal counters to reset values and FSM to IDLE; it SHALL win over any simultaneous event on that cycle.

Reset
REQ-018 On rst_i: error counters 0, max stats 0, min stats all-ones, pixel/line counters 0, FSM IDLE.
REQ-019 Min stats SHALL read all-ones until the first committed sample after reset or clear.
REQ-020 Reset assertion mid-frame SHALL discard all in-progress counts.

Verification
REQ-021 Three frames of 4 lines x 10 px, then one of 2 lines x 6 px -> max_ln 4, min_ln 2, max_px 10, min_px 6.
REQ-022 Beats and eol before first sof, then frame of 3 x 5 -> max_ln=min_ln=3, max_px=min_px=5.
REQ-023 crc_err_i held 5 cycles, clear_stat_i on the 6th with crc_err_i high -> count 5, then 0, stays 0.
REQ-024 Force header_err_cnt_o to all-ones minus 1, pulse twice -> all-ones, no wrap.
REQ-025 Frame: 2 full lines of 8 px, sof without frame_end, then 5 lines x 8 px + frame_end -> max_ln=min_ln=5.
REQ-026 frame_end_i same cycle as final eol of line 3 -> line stat sample 3.

Source files
------------

// File: rtl/csi2_stat_collector.sv
// CSI-2 receive statistics: saturating error counters plus min/max
// lines-per-frame and pixels-per-line tracking for status registers.
module csi2_stat_collector #(
  parameter int unsigned ERR_CNT_WIDTH = 32,
  parameter int unsigned LN_CNT_WIDTH  = 16,
  parameter int unsigned PX_CNT_WIDTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_stat_i,
  input  logic                     header_err_i,
  input  logic                     corr_header_err_i,
  input  logic                     crc_err_i,
  input  logic                     px_valid_i,
  input  logic                     px_sof_i,
  input  logic                     px_eol_i,
  input  logic                     frame_end_i,
  output logic [ERR_CNT_WIDTH-1:0] header_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] corr_header_err_cnt_o,
  output logic [ERR_CNT_WIDTH-1:0] crc_err_cnt_o,
  output logic [LN_CNT_WIDTH-1:0]  max_ln_per_frame_o,
  output logic [LN_CNT_WIDTH-1:0]  min_ln_per_frame_o,
  output logic [PX_CNT_WIDTH-1:0]  max_px_per_ln_o,
  output logic [PX_CNT_WIDTH-1:0]  min_px_per_ln_o
);

  localparam logic [PX_CNT_WIDTH-1:0]  PX_MAX  = '1;
  localparam logic [LN_CNT_WIDTH-1:0]  LN_MAX  = '1;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_MAX = '1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic                    sof_beat_c;
  logic                    count_beat;
  logic                    restart;
  logic                    line_end;
  logic                    frame_commit;
  logic [PX_CNT_WIDTH-1:0] px_cnt;
  logic [PX_CNT_WIDTH-1:0] px_base;
  logic [PX_CNT_WIDTH-1:0] px_len;
  logic [LN_CNT_WIDTH-1:0] ln_cnt;
  logic [LN_CNT_WIDTH-1:0] ln_base;
  logic [LN_CNT_WIDTH-1:0] ln_now;

  function automatic logic [ERR_CNT_WIDTH-1:0] err_inc(
    input logic [ERR_CNT_WIDTH-1:0] cnt,
    input logic                     ev
  );
    return (ev && (cnt != ERR_MAX)) ? cnt + ERR_CNT_WIDTH'(1) : cnt;
  endfunction

  assign sof_beat_c = px_valid_i & px_sof_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; a new sof while active restarts the frame in place
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (sof_beat_c) state_nxt = ST_ACTIVE;
      ST_ACTIVE: if (!sof_beat_c && frame_end_i) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (clear_stat_i) state_nxt = ST_IDLE;
  end

  // Control decode: which datapath actions this cycle performs
  always_comb begin
    count_beat   = 1'b0;
    restart      = 1'b0;
    line_end     = 1'b0;
    frame_commit = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sof_beat_c) begin
          count_beat = 1'b1;
          restart    = 1'b1;
          line_end   = px_eol_i;
        end
      end
      ST_ACTIVE: begin
        if (px_valid_i) begin
          count_beat = 1'b1;
          restart    = px_sof_i;
          line_end   = px_eol_i;
        end
        frame_commit = frame_end_i & ~sof_beat_c;
      end
      default: ;
    endcase
  end

  // Running counts including the current beat, restarted on sof
  always_comb begin
    px_base = restart ? '0 : px_cnt;
    ln_base = restart ? '0 : ln_cnt;
    px_len  = (px_base == PX_MAX) ? PX_MAX : px_base + PX_CNT_WIDTH'(1);
    ln_now  = ln_base;
    if (line_end) ln_now = (ln_base == LN_MAX) ? LN_MAX : ln_base + LN_CNT_WIDTH'(1);
  end

  // Saturating error counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      header_err_cnt_o      <= '0;
      corr_header_err_cnt_o <= '0;
      crc_err_cnt_o         <= '0;
    end else if (clear_stat_i) begin
      header_err_cnt_o      <= '0;
      corr_header_err_cnt_o <= '0;
      crc_err_cnt_o         <= '0;
    end else begin
      header_err_cnt_o      <= err_inc(header_err_cnt_o, header_err_i);
      corr_header_err_cnt_o <= err_inc(corr_header_err_cnt_o, corr_header_err_i);
      crc_err_cnt_o         <= err_inc(crc_err_cnt_o, crc_err_i);
    end
  end

  // Pixel/line counters and min/max statistics
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      px_cnt             <= '0;
      ln_cnt             <= '0;
      max_ln_per_frame_o <= '0;
      min_ln_per_frame_o <= '1;
      max_px_per_ln_o    <= '0;
      min_px_per_ln_o    <= '1;
    end else if (clear_stat_i) begin
      px_cnt             <= '0;
      ln_cnt             <= '0;
      max_ln_per_frame_o <= '0;
      min_ln_per_frame_o <= '1;
      max_px_per_ln_o    <= '0;
      min_px_per_ln_o    <= '1;
    end else begin
      if (frame_commit) begin
        px_cnt <= '0;
        ln_cnt <= '0;
        if (ln_now != '0) begin
          if (ln_now > max_ln_per_frame_o) max_ln_per_frame_o <= ln_now;
          if (ln_now < min_ln_per_frame_o) min_ln_per_frame_o <= ln_now;
        end
      end else if (count_beat) begin
        px_cnt <= line_end ? '0 : px_len;
        ln_cnt <= ln_now;
      end
      if (count_beat && line_end) begin
        if (px_len > max_px_per_ln_o) max_px_per_ln_o <= px_len;
        if (px_len < min_px_per_ln_o) min_px_per_ln_o <= px_len;
      end
    end
  end

endmodule

// File: tb/tb_csi2_stat_collector.sv
// Scoreboard bench for csi2_stat_collector: expected register values are
// queued as stimulus is driven and drained against the DUT outputs.
module tb_csi2_stat_collector;

  localparam int unsigned EW = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned PW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          clear_stat, header_err, corr_header_err, crc_err;
  logic          px_valid, px_sof, px_eol, frame_end;
  logic [EW-1:0] hdr_cnt, corr_cnt, crc_cnt;
  logic [LW-1:0] max_ln, min_ln;
  logic [PW-1:0] max_px, min_px;

  typedef struct {
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csi2_stat_collector #(
    .ERR_CNT_WIDTH(EW),
    .LN_CNT_WIDTH (LW),
    .PX_CNT_WIDTH (PW)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .clear_stat_i         (clear_stat),
    .header_err_i         (header_err),
    .corr_header_err_i    (corr_header_err),
    .crc_err_i            (crc_err),
    .px_valid_i           (px_valid),
    .px_sof_i             (px_sof),
    .px_eol_i             (px_eol),
    .frame_end_i          (frame_end),
    .header_err_cnt_o     (hdr_cnt),
    .corr_header_err_cnt_o(corr_cnt),
    .crc_err_cnt_o        (crc_cnt),
    .max_ln_per_frame_o   (max_ln),
    .min_ln_per_frame_o   (min_ln),
    .max_px_per_ln_o      (max_px),
    .min_px_per_ln_o      (min_px)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic string sel_name(input int sel);
    case (sel)
      0: return "header_err_cnt";
      1: return "corr_header_err_cnt";
      2: return "crc_err_cnt";
      3: return "max_ln";
      4: return "min_ln";
      5: return "max_px";
      default: return "min_px";
    endcase
  endfunction

  function automatic logic [31:0] observe(input int sel);
    case (sel)
      0: return 32'(hdr_cnt);
      1: return 32'(corr_cnt);
      2: return 32'(crc_cnt);
      3: return 32'(max_ln);
      4: return 32'(min_ln);
      5: return 32'(max_px);
      default: return 32'(min_px);
    endcase
  endfunction

  task automatic push(input int sel, input logic [31:0] val);
    exp_t e;
    e.sel = sel;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Compare every queued expectation against the current DUT outputs
  task automatic drain(input string phase);
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val({phase, ".", sel_name(e.sel)}, observe(e.sel), e.val);
    end
  endtask

  task automatic push_stats(input int mxl, input int mnl, input int mxp, input int mnp);
    push(3, 32'(mxl));
    push(4, 32'(mnl));
    push(5, 32'(mxp));
    push(6, 32'(mnp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    clear_stat      = 1'b0;
    header_err      = 1'b0;
    corr_header_err = 1'b0;
    crc_err         = 1'b0;
    px_valid        = 1'b0;
    px_sof          = 1'b0;
    px_eol          = 1'b0;
    frame_end       = 1'b0;
  endtask

  task automatic beat(input logic sof, input logic eol, input logic fe);
    px_valid  = 1'b1;
    px_sof    = sof;
    px_eol    = eol;
    frame_end = fe;
    tick();
    idle_inputs();
  endtask

  task automatic line(input int n, input logic sof_first);
    for (int i = 0; i < n; i++) beat(sof_first && (i == 0), i == n - 1, 1'b0);
  endtask

  task automatic fend();
    frame_end = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic frame(input int lines, input int px);
    for (int l = 0; l < lines; l++) line(px, l == 0);
    fend();
  endtask

  task automatic clear_pulse();
    clear_stat = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    push(0, 0); push(1, 0); push(2, 0);
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("reset");

    // Junk before the first sof must be ignored
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b0);
    fend();
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("pre_sof");
    frame(3, 5);
    push_stats(3, 3, 5, 5);
    drain("frame3x5");

    clear_pulse();
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("clear1");

    // Mixed frame sizes
    frame(4, 10);
    push_stats(4, 4, 10, 10);
    drain("first4x10");
    frame(4, 10);
    frame(4, 10);
    frame(2, 6);
    push_stats(4, 2, 10, 6);
    drain("mixed");

    // Restarted frame: uncommitted lines are discarded
    clear_pulse();
    line(8, 1'b1);
    line(8, 1'b0);
    push_stats(0, 16'hFFFF, 8, 8);
    drain("pre_restart");
    frame(5, 8);
    push_stats(5, 5, 8, 8);
    drain("restart");

    // frame_end on the same cycle as the final eol
    clear_pulse();
    line(7, 1'b1);
    line(7, 1'b0);
    for (int i = 0; i < 6; i++) beat(1'b0, 1'b0, 1'b0);
    beat(1'b0, 1'b1, 1'b1);
    push_stats(3, 3, 7, 7);
    drain("eol_fe");

    // Frame with only a partial line leaves stats alone
    clear_pulse();
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    fend();
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("partial");

    // One-pixel line (sof and eol together), then an equal repeat
    beat(1'b1, 1'b1, 1'b0);
    push_stats(0, 16'hFFFF, 1, 1);
    drain("one_px_line");
    fend();
    push_stats(1, 1, 1, 1);
    drain("one_px_frame");
    frame(1, 1);
    push_stats(1, 1, 1, 1);
    drain("equal");

    // CRC counter with clear winning on the sixth cycle
    for (int c = 1; c <= 5; c++) begin
      crc_err = 1'b1;
      tick();
      push(2, 32'(c));
      drain("crc_inc");
    end
    crc_err         = 1'b1;
    clear_stat      = 1'b1;
    corr_header_err = 1'b1;
    px_valid        = 1'b1;
    px_sof          = 1'b1;
    px_eol          = 1'b1;
    tick();
    idle_inputs();
    push(2, 0); push(1, 0);
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("crc_clear");
    repeat (2) tick();
    push(2, 0);
    drain("crc_hold");

    // Header counter saturation (4-bit counter instance)
    header_err = 1'b1;
    repeat (14) tick();
    header_err = 1'b0;
    push(0, 14);
    drain("hdr_near_max");
    header_err = 1'b1;
    tick();
    push(0, 15);
    drain("hdr_max");
    tick();
    header_err = 1'b0;
    push(0, 15);
    drain("hdr_no_wrap");
    corr_header_err = 1'b1;
    repeat (3) tick();
    corr_header_err = 1'b0;
    push(1, 3); push(2, 0);
    drain("corr");

    // Reset mid-frame discards in-progress counts
    line(5, 1'b1);
    beat(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    push(0, 0); push(1, 0);
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("mid_reset");
    beat(1'b0, 1'b1, 1'b0);
    fend();
    push_stats(0, 16'hFFFF, 0, 16'hFFFF);
    drain("post_reset_idle");
    frame(2, 3);
    push_stats(2, 2, 3, 3);
    drain("post_reset_frame");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
